// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader sitting in front of the pipelined processor's instruction
// fetch. It takes a byte stream of machine code over a valid/ready handshake,
// packs each group of four bytes into a little-endian 32-bit word, writes the
// words to consecutive instruction-memory addresses starting at 0, and keeps
// the pipeline in reset until the whole program is resident. After the last
// word it releases the pipeline and idles until a reload is requested.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a 32-bit wrapping sum of every written word is kept and
//   driven on the checksum port. When undefined, the port and adder are absent.
//
// Parameters
//   ADDR_W      instruction-memory word-address width (capacity 2**ADDR_W words)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   s_valid     byte on s_data is valid
//   s_data      program byte
//   s_last      marks the final byte of the program
//   s_ready     loader accepts a byte this cycle (high only while loading)
//   reload      restart loading; honoured only in RUN or ERROR
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_addr   word address of the write
//   imem_wdata  assembled word
//   cpu_reset   active-high reset to the pipeline
//   load_done   program resident, pipeline released
//   error       load aborted (partial final word or capacity overflow)
//   word_count  number of words written during this load
//   checksum    running sum of written words (macro builds only)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    // Word count value meaning "memory is full": one more word would wrap the
    // address, so any further byte is rejected as an overflow.
    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [1:0]          lane_q, lane_d;
    logic [31:0]         buf_q, buf_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    // Remembers whether the lane-3 byte of the buffered word carried s_last,
    // so WRITE knows whether this is the final word of the program.
    logic                last_q, last_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         csum_q, csum_d;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
            lane_q  <= 2'd0;
            buf_q   <= 32'd0;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        unique case (state_q)
            ST_LOAD: begin
                if (s_valid) begin
                    if (cnt_q == CAPACITY) begin
                        // Memory already full: the byte cannot belong to any
                        // word that fits, so abort before anything wraps.
                        state_d = ST_ERROR;
                    end else begin
                        buf_d[{lane_q, 3'b000} +: 8] = s_data;
                        if (lane_q == 2'd3) begin
                            state_d = ST_WRITE;
                            last_d  = s_last;
                        end else if (s_last) begin
                            // Program ended inside a word.
                            state_d = ST_ERROR;
                        end else begin
                            lane_d = lane_q + 2'd1;
                        end
                    end
                end
            end

            ST_WRITE: begin
                idx_d  = idx_q + ADDR_W'(1);
                cnt_d  = cnt_q + (ADDR_W + 1)'(1);
                lane_d = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d = csum_q + buf_q;
`endif
                state_d = last_q ? ST_RELEASE : ST_LOAD;
            end

            ST_RELEASE: begin
                state_d = ST_RUN;
            end

            ST_RUN, ST_ERROR: begin
                if (reload) begin
                    state_d = ST_LOAD;
                    lane_d  = 2'd0;
                    buf_d   = 32'd0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 32'd0;
`endif
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from registered state, so they change only on the
    // clock edge (or immediately on reset).
    // -------------------------------------------------------------------------
    always_comb begin
        s_ready    = (state_q == ST_LOAD);
        imem_we    = (state_q == ST_WRITE);
        imem_addr  = idx_q;
        imem_wdata = buf_q;
        // The pipeline is held in reset everywhere except RUN, including the
        // single RELEASE cycle after the last write.
        cpu_reset  = (state_q != ST_RUN);
        load_done  = (state_q == ST_RUN);
        error      = (state_q == ST_ERROR);
        word_count = cnt_q;
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader (built with ADDR_W=2 so the capacity
// overflow case is reachable). Expected writes are queued when the stimulus is
// driven and compared by a monitor whenever the DUT strobes imem_we.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_last = 1'b0;
    logic          reload = 1'b0;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          load_done;
    logic          error;
    logic [AW:0]   word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .error      (error),
        .word_count (word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_e;
    int  n_checks = 0;
    int  n_errors = 0;
    int  we_count = 0;
    int  we_base  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (reset_n && imem_we) begin
            we_count++;
            check_eq("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                check_eq("wr_addr", 64'(imem_addr), 64'(exp_e.addr));
                check_eq("wr_data", 64'(imem_wdata), 64'(exp_e.data));
            end
        end
    end

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("ready_wait", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input logic gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], last && (i == 3));
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check_eq("rl_cpu_reset", 64'(cpu_reset), 64'd1);
        check_eq("rl_load_done", 64'(load_done), 64'd0);
        check_eq("rl_s_ready",   64'(s_ready),   64'd1);
        check_eq("rl_error",     64'(error),     64'd0);
        check_eq("rl_count",     64'(word_count), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        // Reset state
        check_eq("rst_s_ready",   64'(s_ready),    64'd1);
        check_eq("rst_we",        64'(imem_we),    64'd0);
        check_eq("rst_addr",      64'(imem_addr),  64'd0);
        check_eq("rst_wdata",     64'(imem_wdata), 64'd0);
        check_eq("rst_cpu_reset", 64'(cpu_reset),  64'd1);
        check_eq("rst_load_done", 64'(load_done),  64'd0);
        check_eq("rst_error",     64'(error),      64'd0);
        check_eq("rst_count",     64'(word_count), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("rst_checksum",  64'(checksum),   64'd0);
`endif
        reset_n = 1'b1;

        // Two-word program, back-to-back bytes, with release timing
        expect_wr(2'd0, 32'h0A000013);
        expect_wr(2'd1, 32'h78000000);
        send_word(32'h0A000013, 1'b0, 1'b0);
        send_word(32'h78000000, 1'b1, 1'b0);
        check_eq("t1_we",        64'(imem_we),   64'd1);
        check_eq("t1_bubble",    64'(s_ready),   64'd0);
        wait_cycles(1);
        check_eq("t2_cpu_reset", 64'(cpu_reset), 64'd1);
        check_eq("t2_load_done", 64'(load_done), 64'd0);
        wait_cycles(1);
        check_eq("t3_cpu_reset", 64'(cpu_reset), 64'd0);
        check_eq("t3_load_done", 64'(load_done), 64'd1);
        check_eq("t3_count",     64'(word_count), 64'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("t3_checksum",  64'(checksum),  64'h82000013);
`endif

        // Reload from RUN, single-word program
        pulse_reload();
        expect_wr(2'd0, 32'hDEADBEEF);
        send_word(32'hDEADBEEF, 1'b1, 1'b0);
        wait_cycles(3);
        check_eq("one_load_done", 64'(load_done), 64'd1);
        check_eq("one_count",     64'(word_count), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("one_checksum",  64'(checksum),  64'hDEADBEEF);
`endif

        // Same two-word stream with s_valid toggling
        pulse_reload();
        we_base = we_count;
        expect_wr(2'd0, 32'h0A000013);
        expect_wr(2'd1, 32'h78000000);
        send_word(32'h0A000013, 1'b0, 1'b1);
        send_word(32'h78000000, 1'b1, 1'b1);
        wait_cycles(4);
        check_eq("gap_we_count",  64'(we_count - we_base), 64'd2);
        check_eq("gap_load_done", 64'(load_done), 64'd1);
        check_eq("gap_cpu_reset", 64'(cpu_reset), 64'd0);
        check_eq("gap_count",     64'(word_count), 64'd2);

        // Six bytes, last on the sixth: partial word aborts
        pulse_reload();
        we_base = we_count;
        expect_wr(2'd0, 32'h44332211);
        send_word(32'h44332211, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        check_eq("part_error",     64'(error),     64'd1);
        check_eq("part_cpu_reset", 64'(cpu_reset), 64'd1);
        wait_cycles(4);
        check_eq("part_we_count",  64'(we_count - we_base), 64'd1);
        check_eq("part_error_hold", 64'(error),    64'd1);
        check_eq("part_load_done", 64'(load_done), 64'd0);
        check_eq("part_count",     64'(word_count), 64'd1);

        // Capacity overflow: four words fill memory, 17th byte aborts
        pulse_reload();
        we_base = we_count;
        for (int i = 0; i < 4; i++) begin
            expect_wr(AW'(i), 32'h1000_0000 + 32'(i * 32'h0101_0101));
            send_word(32'h1000_0000 + 32'(i * 32'h0101_0101), 1'b0, 1'b0);
        end
        send_byte(8'hAA, 1'b1);
        check_eq("ovf_error",     64'(error),      64'd1);
        check_eq("ovf_count",     64'(word_count), 64'd4);
        wait_cycles(3);
        check_eq("ovf_we_count",  64'(we_count - we_base), 64'd4);
        check_eq("ovf_cpu_reset", 64'(cpu_reset),  64'd1);

        // Asynchronous reset in the middle of a word
        pulse_reload();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_wdata",     64'(imem_wdata), 64'd0);
        check_eq("arst_s_ready",   64'(s_ready),    64'd1);
        check_eq("arst_cpu_reset", 64'(cpu_reset),  64'd1);
        check_eq("arst_count",     64'(word_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_wr(2'd0, 32'hCAFEF00D);
        send_word(32'hCAFEF00D, 1'b1, 1'b0);
        wait_cycles(3);
        check_eq("arst_load_done", 64'(load_done),  64'd1);
        check_eq("arst_count2",    64'(word_count), 64'd1);

        wait_cycles(2);
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that sits directly upstream of the pipelined SimpleRisc processor's instruction fetch. It accepts a byte stream of `.encode` machine code over a valid/ready handshake, assembles little-endian 32-bit words, writes them sequentially into instruction memory, and holds the pipeline in reset until the whole program is resident. It then releases the pipeline and idles until a reload is requested.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: byte on `s_data` is valid.
- `s_data` in 8: program byte.
- `s_last` in 1: qualifies the final byte of the program.
- `s_ready` out 1: loader accepts a byte this cycle.
- `reload` in 1: restart loading; honoured only in RUN or ERROR.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out ADDR_W: word address for the write.
- `imem_wdata` out 32: assembled word.
- `cpu_reset` out 1: active-high reset to the pipeline (drives its `reset`).
- `load_done` out 1: program resident, pipeline released.
- `error` out 1: load aborted (partial word or overflow).
- `word_count` out ADDR_W+1: number of words written this load.
- `checksum` out 32: present only with `IMEM_LOADER_CHECKSUM_EN`.

## Operation
- Byte accepted on `s_valid && s_ready`. `s_ready = (state == LOAD)`.
- Byte lane counter 0..3; byte k goes to bits [8k+7:8k] of the word buffer (little-endian).
- States: LOAD, WRITE, RELEASE, RUN, ERROR.
- LOAD: accept bytes. On acceptance of lane 3 -> WRITE. On `s_last` with lane != 3 -> ERROR. On any accepted byte when `word_count == 2^ADDR_W` -> ERROR.
- WRITE: `imem_we=1`, `imem_addr` = current word index, `imem_wdata` = buffer; index and `word_count` increment; lane cleared. Next: RELEASE if that word's lane-3 byte had `s_last`, else LOAD.
- RELEASE: one cycle, `cpu_reset` still 1. Next: RUN.
- RUN: `cpu_reset=0`, `load_done=1`. `reload` -> LOAD.
- ERROR: `error=1`, `cpu_reset=1`, no further writes; `reload` -> LOAD.
- Entering LOAD via `reload`: word index, `word_count`, lane, buffer, `error`, `load_done` cleared; `cpu_reset` reasserted.
- Index wraps never occur: overflow is detected before the write and goes to ERROR.

## Timing
- Reset values: state LOAD, `s_ready` 1, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_reset` 1, `load_done` 0, `error` 0, `word_count` 0, `checksum` 0.
- Reset mid-load: immediate return to reset values; partially written memory is not cleared.
- Lane-3 byte at cycle t -> `imem_we` at t+1; `s_ready` low at t+1 (one bubble per word).
- Last word write at t+1, RELEASE at t+2, `cpu_reset` falls and `load_done` rises at t+3.
- `reload` sampled at t -> `cpu_reset` 1, `load_done` 0, `s_ready` 1 at t+1.
- Gaps in `s_valid` are allowed anywhere; no timeout.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: 32-bit wrapping sum of every written word, updated in WRITE, cleared on reset/reload, driven on `checksum`.
- Undefined: `checksum` port and adder absent; all other behaviour identical.

## Test plan
- Load bytes 13 00 00 0A, 00 00 00 78 (last): writes 0x0A000013 @0, 0x78000000 @1; `word_count`=2; `load_done`=1 and `cpu_reset`=0 three cycles after last byte.
- Same stream with `s_valid` toggling every other cycle: identical writes and final state, `imem_we` exactly twice.
- Six bytes, `s_last` on 6th: one write @0, then `error`=1, `cpu_reset` stays 1, no second write.
- ADDR_W=2, 17 bytes: four writes @0..3, 17th byte -> ERROR, `word_count`=4.
- After RUN, pulse `reload`, load one word 0xDEADBEEF: written @0, `word_count`=1; with macro `checksum`=0xDEADBEEF.
- Assert `reset_n` low after two bytes: outputs return to reset values immediately; fresh 4-byte load writes @0.
